// File: rtl/lin_mul_add.sv
// lin_mul_add: multi-lane streaming gain/offset stage.
// sto = sat(round((sti * mul) >>> SHF) + sum), three pipeline stages with
// valid/ready backpressure, packet-aligned double-buffered gain/offset and
// a saturating count of beats that clipped on at least one kept lane.
module lin_mul_add #(
    parameter int DN  = 1,
    parameter int DWI = 14,
    parameter int DWO = 14,
    parameter int DWM = 16,
    parameter int SHF = DWM - 2,
    parameter int RND = 1,
    parameter int DWC = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [DN*DWI-1:0] sti_tdata,
    input  logic [DN-1:0]     sti_tkeep,
    input  logic              sti_tlast,
    input  logic              sti_tvalid,
    output logic              sti_tready,
    output logic [DN*DWO-1:0] sto_tdata,
    output logic [DN-1:0]     sto_tkeep,
    output logic              sto_tlast,
    output logic              sto_tvalid,
    input  logic              sto_tready,
    input  logic [DWM-1:0]    cfg_mul,
    input  logic [DWO-1:0]    cfg_sum,
    input  logic              cfg_upd,
    output logic [DWC-1:0]    sts_sat,
    input  logic              sts_clr
);

    localparam int PW = DWI + DWM;
    localparam int RW = PW - SHF;
    localparam int SW = ((RW > DWO) ? RW : DWO) + 1;

    localparam logic signed [PW:0]    C_RND  = (RND != 0) ? ((PW+1)'(1) <<< (SHF-1)) : '0;
    localparam logic signed [SW-1:0]  C_SMAX = SW'({1'b0, {(DWO-1){1'b1}}});
    localparam logic signed [SW-1:0]  C_SMIN = ~C_SMAX;
    localparam logic [DWO-1:0]        C_OMAX = {1'b0, {(DWO-1){1'b1}}};
    localparam logic [DWO-1:0]        C_OMIN = ~C_OMAX;

    logic                  w_en1, w_en2, w_en3;
    logic                  w_xfer, w_load, w_bsat;
    logic                  r_v1, r_v2, r_v3;
    logic signed [DWM-1:0] r_mul;
    logic signed [DWO-1:0] r_sum;
    logic                  r_pend, r_inpkt;
    logic [DWC-1:0]        r_sat;

    logic signed [PW-1:0]  r_p1 [DN];
    logic signed [DWO-1:0] r_sum1;
    logic [DN-1:0]         r_k1, r_k2, r_k3;
    logic                  r_l1, r_l2, r_l3;
    logic signed [SW-1:0]  r_s2 [DN];
    logic [DWO-1:0]        r_d3 [DN];

    logic signed [PW-1:0]  w_prod [DN];
    logic signed [SW-1:0]  w_s    [DN];
    logic [DWO-1:0]        w_clip [DN];
    logic [DN-1:0]         w_lsat;

    // Each stage advances when the one downstream can take data or it is empty.
    assign w_en3  = sto_tready | ~r_v3;
    assign w_en2  = w_en3 | ~r_v2;
    assign w_en1  = w_en2 | ~r_v1;
    assign w_xfer = sti_tvalid & w_en1;
    // Shadow config is applied at a packet boundary: on the last beat, or when idle between packets.
    assign w_load = r_pend & (w_xfer ? sti_tlast : ~r_inpkt);
    assign w_bsat = |w_lsat;

    for (genvar gi = 0; gi < DN; gi++) begin : g_lane
        logic signed [DWI-1:0] w_x;
        logic signed [RW:0]    w_r;
        assign w_x          = sti_tdata[gi*DWI +: DWI];
        assign w_prod[gi]   = PW'(w_x) * PW'(r_mul);
        assign w_r          = (RW+1)'(((PW+1)'(r_p1[gi]) + C_RND) >>> SHF);
        assign w_s[gi]      = SW'(w_r) + SW'(r_sum1);
        assign w_lsat[gi]   = r_k2[gi] & ((r_s2[gi] > C_SMAX) | (r_s2[gi] < C_SMIN));
        assign w_clip[gi]   = (r_s2[gi] > C_SMAX) ? C_OMAX :
                              (r_s2[gi] < C_SMIN) ? C_OMIN : r_s2[gi][DWO-1:0];
        assign sto_tdata[gi*DWO +: DWO] = r_d3[gi];
    end

    // Stage valid flags move forward whenever their stage is enabled.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= sti_tvalid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
        end
    end

    // Active gain/offset, pending update request and packet tracking.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_mul   <= '0;
            r_sum   <= '0;
            r_pend  <= 1'b0;
            r_inpkt <= 1'b0;
        end else begin
            if (w_load) begin
                r_mul <= cfg_mul;
                r_sum <= cfg_sum;
            end
            if (cfg_upd) r_pend <= 1'b1;
            else if (w_load) r_pend <= 1'b0;
            if (w_xfer) r_inpkt <= ~sti_tlast;
        end
    end

    // Saturation event counter, clear has priority and the count sticks at all-ones.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_sat <= '0;
        else if (sts_clr) r_sat <= '0;
        else if (w_en3 & r_v2 & w_bsat & ~&r_sat) r_sat <= r_sat + DWC'(1);
    end

    // Data path registers: multiply, round/shift/offset, clip; keep/last ride along.
    always_ff @(posedge ACLK) begin
        if (w_en1) begin
            for (int i = 0; i < DN; i++) r_p1[i] <= w_prod[i];
            r_sum1 <= r_sum;
            r_k1   <= sti_tkeep;
            r_l1   <= sti_tlast;
        end
        if (w_en2) begin
            for (int i = 0; i < DN; i++) r_s2[i] <= w_s[i];
            r_k2 <= r_k1;
            r_l2 <= r_l1;
        end
        if (w_en3) begin
            for (int i = 0; i < DN; i++) r_d3[i] <= w_clip[i];
            r_k3 <= r_k2;
            r_l3 <= r_l2;
        end
    end

    assign sti_tready = w_en1;
    assign sto_tvalid = r_v3;
    assign sto_tkeep  = r_k3;
    assign sto_tlast  = r_l3;
    assign sts_sat    = r_sat;

endmodule
